// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS control unit: opcode values,
// FSM state encodings, datapath mux/ALU codes, the control output bundle and
// the DECODE-state dispatch function.
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

   // Opcode field values (instruction[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // FSM state encodings; 13..15 are unused and recover into S_TRAP
   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_ALUWB  = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_ADDIEX = 4'd9;
   localparam logic [3:0] S_ADDIWB = 4'd10;
   localparam logic [3:0] S_JUMP   = 4'd11;
   localparam logic [3:0] S_TRAP   = 4'd12;

   // ALU operation select
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // ALU B operand select
   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Complete control output bundle driven towards the datapath
   typedef struct packed {
      logic       mem_req;
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic       branch_eq;
      logic       branch_ne;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       retire;
      logic       illegal;
   } ctrl_t;

   // State entered after DECODE for a given opcode; unknown opcodes trap.
   function automatic logic [3:0] decode_target(input logic [5:0] op);
      logic [3:0] target;
      case (op)
         OP_RTYPE:       target = S_EXEC;
         OP_LW, OP_SW:   target = S_MEMADR;
         OP_BEQ, OP_BNE: target = S_BRANCH;
         OP_ADDI:        target = S_ADDIEX;
         OP_J:           target = S_JUMP;
         default:        target = S_TRAP;
      endcase
      return target;
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// ---------------------------------------------------------------------------
// mc_ctrl_decode
// Purely combinational Moore decode: current FSM state (plus the opcode
// latched in DECODE, used only to pick beq vs bne) -> control bundle.
// Handshake gating and reset forcing are applied by the parent.
// Ports:
//   i_state   current FSM state
//   i_opcode  opcode captured during DECODE
//   o_ctrl    ungated control outputs for this state
// ---------------------------------------------------------------------------
module mc_ctrl_decode
   import mips_ctrl_pkg::*;
#(
   parameter int STATE_W  = 4,
   parameter int OPCODE_W = 6
) (
   input  logic [STATE_W-1:0]  i_state,
   input  logic [OPCODE_W-1:0] i_opcode,
   output ctrl_t               o_ctrl
);

   always_comb begin
      // NOTE: every field gets a default before the case so that states which
      // leave a field untouched never imply a latch.
      o_ctrl = '0;
      case (i_state)
         S_FETCH: begin
            o_ctrl.mem_req   = 1'b1;
            o_ctrl.ir_write  = 1'b1;
            o_ctrl.pc_write  = 1'b1;
            o_ctrl.alu_src_b = SRCB_FOUR;
            o_ctrl.alu_op    = ALU_ADD;
            o_ctrl.pc_src    = PCSRC_ALU;
         end
         S_DECODE: begin
            // Speculative branch target: PC + (imm << 2)
            o_ctrl.alu_src_b = SRCB_IMM_SH2;
            o_ctrl.alu_op    = ALU_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = ALU_ADD;
         end
         S_MEMRD: begin
            o_ctrl.mem_req = 1'b1;
            o_ctrl.iord    = 1'b1;
         end
         S_MEMWB: begin
            o_ctrl.mem_to_reg = 1'b1;
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.retire     = 1'b1;
         end
         S_MEMWR: begin
            o_ctrl.mem_req   = 1'b1;
            o_ctrl.iord      = 1'b1;
            o_ctrl.mem_write = 1'b1;
            o_ctrl.retire    = 1'b1;
         end
         S_EXEC: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_RT;
            o_ctrl.alu_op    = ALU_FUNCT;
         end
         S_ALUWB: begin
            o_ctrl.reg_dst   = 1'b1;
            o_ctrl.reg_write = 1'b1;
            o_ctrl.retire    = 1'b1;
         end
         S_BRANCH: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_RT;
            o_ctrl.alu_op    = ALU_SUB;
            o_ctrl.pc_src    = PCSRC_ALUOUT;
            o_ctrl.retire    = 1'b1;
            // Exact compares keep the two branch enables mutually exclusive
            o_ctrl.branch_eq = (i_opcode == OP_BEQ);
            o_ctrl.branch_ne = (i_opcode == OP_BNE);
         end
         S_ADDIWB: begin
            o_ctrl.reg_write = 1'b1;
            o_ctrl.retire    = 1'b1;
         end
         S_JUMP: begin
            o_ctrl.pc_src   = PCSRC_JUMP;
            o_ctrl.pc_write = 1'b1;
            o_ctrl.retire   = 1'b1;
         end
         S_TRAP: begin
            o_ctrl.illegal = 1'b1;
         end
         default: begin
            // Unused encodings drive nothing; the FSM moves them to S_TRAP
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
// Multi-cycle MIPS control FSM. Steps each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and drives datapath enables
// and mux selects, with a memory ready handshake, a retire pulse and a
// sticky illegal-opcode trap.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   opcode           instruction[31:26] from the IR
//   mem_ready        memory access completes this cycle
//   mem_req..pc_src  datapath controls
//   retire           one-cycle pulse in the final state of an instruction
//   illegal          sticky illegal-opcode flag (held in TRAP)
//   state            current FSM state, for debug
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
   parameter int OPCODE_W      = 6,
   parameter int STATE_W       = 4,
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                iord,
   output logic                mem_write,
   output logic                ir_write,
   output logic                pc_write,
   output logic                branch_eq,
   output logic                branch_ne,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          alu_op,
   output logic [1:0]          pc_src,
   output logic                retire,
   output logic                illegal,
   output logic [STATE_W-1:0]  state
);

   import mips_ctrl_pkg::*;

   logic [STATE_W-1:0]  r_state;
   logic [STATE_W-1:0]  w_next_state;
   logic [OPCODE_W-1:0] r_opcode;
   logic                w_mem_ready;
   ctrl_t               w_ctrl_moore;
   ctrl_t               w_ctrl;

   // Without the handshake every memory access completes in one cycle
   assign w_mem_ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

   // State register; the opcode is captured in DECODE so that BRANCH can
   // tell beq from bne without looking at the live IR field.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_FETCH;
         r_opcode <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         r_state <= w_next_state;
         if (r_state == S_DECODE) begin
            r_opcode <= opcode;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_FETCH:  if (w_mem_ready) w_next_state = S_DECODE;
         S_DECODE: w_next_state = decode_target(opcode);
         S_MEMADR: begin
            if (opcode == OP_LW) begin
               w_next_state = S_MEMRD;
            end else if (opcode == OP_SW) begin
               w_next_state = S_MEMWR;
            end else begin
               // Opcode no longer a memory op: treat as illegal
               w_next_state = S_TRAP;
            end
         end
         S_MEMRD:  if (w_mem_ready) w_next_state = S_MEMWB;
         S_MEMWB:  w_next_state = S_FETCH;
         S_MEMWR:  if (w_mem_ready) w_next_state = S_FETCH;
         S_EXEC:   w_next_state = S_ALUWB;
         S_ALUWB:  w_next_state = S_FETCH;
         S_BRANCH: w_next_state = S_FETCH;
         S_ADDIEX: w_next_state = S_ADDIWB;
         S_ADDIWB: w_next_state = S_FETCH;
         S_JUMP:   w_next_state = S_FETCH;
         S_TRAP:   w_next_state = S_TRAP;
         default:  w_next_state = S_TRAP;
      endcase
   end

   mc_ctrl_decode #(
      .STATE_W  (STATE_W),
      .OPCODE_W (OPCODE_W)
   ) u_decode (
      .i_state  (r_state),
      .i_opcode (r_opcode),
      .o_ctrl   (w_ctrl_moore)
   );

   // Handshake gating: IR/PC load only on the completing fetch cycle and the
   // store retires only when its write is accepted. Reset forces everything
   // low combinationally so no partial write can leak out mid-instruction.
   always_comb begin
      w_ctrl = w_ctrl_moore;
      if (r_state == S_FETCH) begin
         w_ctrl.ir_write = w_ctrl_moore.ir_write & w_mem_ready;
         w_ctrl.pc_write = w_ctrl_moore.pc_write & w_mem_ready;
      end
      if (r_state == S_MEMWR) begin
         w_ctrl.retire = w_ctrl_moore.retire & w_mem_ready;
      end
      if (!rst_n) begin
         w_ctrl = '0;
      end
   end

   assign mem_req    = w_ctrl.mem_req;
   assign iord       = w_ctrl.iord;
   assign mem_write  = w_ctrl.mem_write;
   assign ir_write   = w_ctrl.ir_write;
   assign pc_write   = w_ctrl.pc_write;
   assign branch_eq  = w_ctrl.branch_eq;
   assign branch_ne  = w_ctrl.branch_ne;
   assign reg_dst    = w_ctrl.reg_dst;
   assign mem_to_reg = w_ctrl.mem_to_reg;
   assign reg_write  = w_ctrl.reg_write;
   assign alu_src_a  = w_ctrl.alu_src_a;
   assign alu_src_b  = w_ctrl.alu_src_b;
   assign alu_op     = w_ctrl.alu_op;
   assign pc_src     = w_ctrl.pc_src;
   assign retire     = w_ctrl.retire;
   assign illegal    = w_ctrl.illegal;
   assign state      = r_state;

endmodule
